// File: rtl/param_seq_detector.sv
// Programmable serial pattern detector: run-time loadable pattern with per-bit
// don't-care mask, overlap/non-overlap mode, Mealy match and saturating count.
module param_seq_detector #(
  parameter int unsigned      PAT_W           = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT     = PAT_W'(4'b1011),
  parameter bit               OVERLAP_DEFAULT = 1'b1,
  parameter int unsigned      CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             d_i,
  input  logic             load_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [PAT_W-1:0] mask_i,
  input  logic             overlap_i,
  input  logic             clr_i,
  output logic             pattern_o,
  output logic             match_q_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned      FillW    = $clog2(PAT_W);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [PAT_W-2:0] sr_q, sr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic             overlap_q, overlap_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PAT_W-1:0] cand;
  logic             accept;
  logic             win_full;
  logic             hit;

  always_comb begin
    cand     = {sr_q, d_i};
    accept   = valid_i & ~load_i;
    win_full = (fill_q == FillFull);
    hit      = accept & win_full & (((cand ^ pat_q) & mask_q) == '0);
  end

  assign pattern_o = hit;
  assign match_q_o = match_q;
  assign count_o   = count_q;

  always_comb begin
    sr_d      = sr_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    match_d   = hit;
    count_d   = count_q;

    if (load_i) begin
      // Loading drops any coincident stream bit and restarts the window fill.
      pat_d     = pat_i;
      mask_d    = mask_i;
      overlap_d = overlap_i;
      fill_d    = '0;
    end else if (accept) begin
      sr_d = cand[PAT_W-2:0];
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (!win_full) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (clr_i) begin
      count_d = '0;
    end else if (hit && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q      <= '0;
      fill_q    <= '0;
      pat_q     <= PAT_DEFAULT;
      mask_q    <= '1;
      overlap_q <= OVERLAP_DEFAULT;
      match_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Programmable serial pattern detector with Mealy output. It is the parametrised successor of the fixed single-pattern overlapping Mealy detector. It scans a valid-qualified 1-bit stream for a run-time loadable PAT_W-bit pattern with a per-bit don't-care mask and a selectable overlap/non-overlap mode. It also keeps a saturating match counter. It sits between a serial bit source and status/interrupt logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32.
PAT_DEFAULT, 4'b1011, pattern loaded at reset; MSB is the first bit received.
OVERLAP_DEFAULT, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping).
CNT_W, 16, width of the match counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  d_i carries a stream bit this cycle.
d_i  input  1  serial data bit.
load_i  input  1  load pat_i/mask_i/overlap_i into config registers and flush the window.
pat_i  input  PAT_W  new pattern; MSB = oldest bit.
mask_i  input  PAT_W  new mask; 1 = compare bit, 0 = don't care.
overlap_i  input  1  new overlap mode.
clr_i  input  1  synchronous clear of count_o.
pattern_o  output  1  Mealy match, combinational, same cycle as final pattern bit.
match_q_o  output  1  pattern_o registered (one-cycle-delayed pulse).
count_o  output  CNT_W  saturating number of matches.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - window shift register sr (PAT_W-1 bits) = 0; fill counter = 0.
  - pat register = PAT_DEFAULT; mask register = all ones; overlap register = OVERLAP_DEFAULT.
  - pattern_o = 0 (no valid_i possible in a meaningful sense); match_q_o = 0; count_o = 0.
- Accepted bit: valid_i=1 and load_i=0. When valid_i=0, nothing changes and pattern_o=0.
- Candidate window = {sr, d_i}; d_i is the newest bit and sits at bit 0.
- pattern_o = accepted & (fill == PAT_W-1) & ((candidate ^ pat) & mask) == 0.
  - This gives zero latency: the match is visible in the cycle the last bit is presented.
- Fill counter on an accepted bit:
  - pattern_o=1 and overlap=0: fill <= 0 (the matched bits are consumed).
  - Otherwise: fill <= min(fill+1, PAT_W-1).
  - sr always shifts in d_i on an accepted bit, including in non-overlap mode; only fill is reset.
- Load:
  - load_i=1 captures pat_i, mask_i and overlap_i, and sets fill <= 0.
  - A coincident d_i bit is dropped and pattern_o=0. Load has priority over valid_i.
- Counter:
  - On pattern_o=1, count_o increments, saturating at 2^CNT_W-1 with no wrap.
  - clr_i=1 sets count_o <= 0 and has priority over a coincident match (that match is not counted).
  - match_q_o is still asserted next cycle.
- match_q_o <= pattern_o every cycle.
- Mask all zero: every accepted bit after the window has filled matches. This is legal.
- Reset asserted mid-stream: all state returns to reset values immediately, including the config registers. The previously loaded pattern is lost.

Test Plan:
- Defaults (1011, overlap): after reset, stream 1,0,1,1,0,1,1 with valid_i=1 -> pattern_o high on the 4th and 7th bits, in the same cycle; match_q_o one cycle later; count_o=2.
- Non-overlap: load pat=1011, mask=1111, overlap=0; stream 1,0,1,1,0,1,1 -> pattern_o only on the 4th bit; count_o=1. Follow with 0,1,1 -> second match on the 10th bit; count_o=2.
- Valid gaps and load collision:
  - Stream 1,0,1,1 with valid_i=0 cycles between bits (d_i toggling randomly during gaps) -> exactly one match.
  - load_i asserted together with the 3rd bit -> no match until 4 new accepted bits.
- Mask: load pat=1001, mask=1001; streams 1011 and 1101 -> both match; stream 0111 -> no match.
- Counter: CNT_W=4, repeat pattern 20 times -> count_o saturates at 15. clr_i coincident with a match -> count_o=0 and match_q_o=1 next cycle.
- Reset mid-operation: load pat=0110, then feed 3 bits, then pulse rst_ni low asynchronously (mid-cycle) -> outputs 0 immediately. After release, stream 1011 matches (PAT_DEFAULT restored) and stream 0110 does not. Random 600-bit stream is checked against a reference model count.
